// File: rtl/bp_me_cache_pkt_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bp_me_cache_pkt_arbiter_if                                                 |
// | Requester-side and cache-side packet/response bundle for the arbiter.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface bp_me_cache_pkt_arbiter_if #(
  parameter int num_req_p     = 2,
  parameter int paddr_width_p = 40,
  parameter int data_width_p  = 64
);
  // opcode + address + data + byte mask
  localparam int bsg_cache_pkt_width_lp = 6 + paddr_width_p + data_width_p + (data_width_p >> 3);

  logic [num_req_p*bsg_cache_pkt_width_lp-1:0] req_pkt_i;
  logic [num_req_p-1:0]                        req_v_i;
  logic [num_req_p-1:0]                        req_lock_i;
  logic [num_req_p-1:0]                        req_ready_o;
  logic [data_width_p-1:0]                     req_data_o;
  logic [num_req_p-1:0]                        req_v_o;
  logic [num_req_p-1:0]                        req_yumi_i;
  logic [bsg_cache_pkt_width_lp-1:0]           cache_pkt_o;
  logic                                        cache_pkt_v_o;
  logic                                        cache_pkt_ready_i;
  logic [data_width_p-1:0]                     cache_data_i;
  logic                                        cache_v_i;
  logic                                        cache_yumi_o;

  modport slave (
    input  req_pkt_i, req_v_i, req_lock_i, req_yumi_i,
    input  cache_pkt_ready_i, cache_data_i, cache_v_i,
    output req_ready_o, req_data_o, req_v_o,
    output cache_pkt_o, cache_pkt_v_o, cache_yumi_o
  );

  modport master (
    output req_pkt_i, req_v_i, req_lock_i, req_yumi_i,
    output cache_pkt_ready_i, cache_data_i, cache_v_i,
    input  req_ready_o, req_data_o, req_v_o,
    input  cache_pkt_o, cache_pkt_v_o, cache_yumi_o
  );
endinterface
`default_nettype wire

// File: rtl/bp_me_cache_pkt_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bp_me_cache_pkt_arbiter                                                    |
// | Round-robin/lockable arbiter sharing one bsg_cache packet port, with an   |
// | order FIFO steering in-order responses back to their requesters.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bp_me_cache_pkt_arbiter #(
  parameter int num_req_p         = 2,
  parameter int paddr_width_p     = 40,
  parameter int data_width_p      = 64,
  parameter int outstanding_els_p = 4
) (
  input  wire logic                clk_i,
  input  wire logic                reset_i,
  bp_me_cache_pkt_arbiter_if.slave bus
);

  localparam int bsg_cache_pkt_width_lp = 6 + paddr_width_p + data_width_p + (data_width_p >> 3);
  localparam int lg_req_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int lg_els_lp    = (outstanding_els_p > 1) ? $clog2(outstanding_els_p) : 1;
  localparam int cnt_width_lp = $clog2(outstanding_els_p + 1);

  localparam logic [lg_req_lp-1:0]    c_last_rst = lg_req_lp'(num_req_p - 1);
  localparam logic [lg_els_lp-1:0]    c_ptr_max  = lg_els_lp'(outstanding_els_p - 1);
  localparam logic [cnt_width_lp-1:0] c_cnt_full = cnt_width_lp'(outstanding_els_p);

  logic                    r_reset_q;
  logic [lg_req_lp-1:0]    r_last;
  logic                    r_locked;
  logic [lg_req_lp-1:0]    r_owner;
  logic [lg_req_lp-1:0]    r_fifo_mem [outstanding_els_p];
  logic [lg_els_lp-1:0]    r_wptr;
  logic [lg_els_lp-1:0]    r_rptr;
  logic [cnt_width_lp-1:0] r_count;

  logic                    w_out_en;
  logic                    w_fifo_ready;
  logic                    w_fifo_v;
  logic                    w_can_issue;
  logic [num_req_p-1:0]    w_elig;
  logic [num_req_p-1:0]    w_grant;
  logic [lg_req_lp-1:0]    w_grant_idx;
  logic [lg_req_lp-1:0]    w_idx_sel;
  logic                    w_found;
  int                      w_idx;
  logic [lg_req_lp-1:0]    w_head;
  logic                    w_resp_v;
  logic                    w_deq;

  function automatic logic [lg_els_lp-1:0] f_ptr_inc(input logic [lg_els_lp-1:0] p);
    return (p == c_ptr_max) ? '0 : p + 1'b1;
  endfunction

  // Outputs stay quiet through reset and the first cycle after it.
  assign w_out_en     = ~reset_i & ~r_reset_q;
  assign w_fifo_ready = (r_count != c_cnt_full);
  assign w_fifo_v     = (r_count != '0);
  assign w_can_issue  = w_out_en & bus.cache_pkt_ready_i & w_fifo_ready;

  for (genvar i = 0; i < num_req_p; i++) begin : g_elig
    assign w_elig[i] = bus.req_v_i[i] & (~r_locked | (r_owner == lg_req_lp'(i)));
  end

  // Search starts one past the last grantee and wraps.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_idx       = 0;
    w_idx_sel   = '0;
    for (int off = 1; off <= num_req_p; off++) begin
      w_idx     = (int'(r_last) + off) % num_req_p;
      w_idx_sel = lg_req_lp'(w_idx);
      if (w_can_issue && !w_found && w_elig[w_idx_sel]) begin
        w_found     = 1'b1;
        w_grant_idx = w_idx_sel;
      end
    end
  end

  always_comb begin
    w_grant              = '0;
    w_grant[w_grant_idx] = w_found;
  end

  assign bus.req_ready_o   = w_grant;
  assign bus.cache_pkt_v_o = w_found;
  assign bus.cache_pkt_o   = bus.req_pkt_i[w_grant_idx*bsg_cache_pkt_width_lp +: bsg_cache_pkt_width_lp];

  assign w_head   = r_fifo_mem[r_rptr];
  assign w_resp_v = w_out_en & bus.cache_v_i & w_fifo_v;
  assign w_deq    = w_resp_v & bus.req_yumi_i[w_head];

  always_comb begin
    bus.req_v_o         = '0;
    bus.req_v_o[w_head] = w_resp_v;
  end

  assign bus.req_data_o   = bus.cache_data_i;
  assign bus.cache_yumi_o = w_deq;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_reset_q <= 1'b1;
      r_last    <= c_last_rst;
      r_locked  <= 1'b0;
      r_owner   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else begin
      r_reset_q <= 1'b0;
      if (w_found) begin
        r_last   <= w_grant_idx;
        r_locked <= bus.req_lock_i[w_grant_idx];
        if (bus.req_lock_i[w_grant_idx]) begin
          r_owner <= w_grant_idx;
        end
        r_wptr <= f_ptr_inc(r_wptr);
      end
      if (w_deq) begin
        r_rptr <= f_ptr_inc(r_rptr);
      end
      case ({w_found, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (w_found) begin
      r_fifo_mem[r_wptr] <= w_grant_idx;
    end
  end

  a_resp_with_outstanding : assert property (@(posedge clk_i) disable iff (reset_i)
    bus.cache_v_i |-> w_fifo_v);

endmodule
`default_nettype wire

// File: tb/tb_bp_me_cache_pkt_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bp_me_cache_pkt_arbiter                                                 |
// | Randomized scoreboard bench with a behavioural arbiter/cache model.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bp_me_cache_pkt_arbiter;
  localparam int N     = 2;
  localparam int PADDR = 40;
  localparam int DATA  = 64;
  localparam int ELS   = 4;
  localparam int W     = 6 + PADDR + DATA + (DATA >> 3);

  typedef struct {
    int              g;
    logic [DATA-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bp_me_cache_pkt_arbiter_if #(.num_req_p(N), .paddr_width_p(PADDR), .data_width_p(DATA)) bus ();

  bp_me_cache_pkt_arbiter #(
    .num_req_p(N), .paddr_width_p(PADDR), .data_width_p(DATA), .outstanding_els_p(ELS)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  exp_t          sb[$];
  logic [W-1:0]  cq[$];
  logic [W-1:0]  pkt [N];
  int            m_last, m_owner;
  bit            m_locked;
  bit            m_quiet = 1'b1;
  bit            resp_en = 1'b0;
  logic [N-1:0]  yumi_knob = '1;
  int            checks = 0;
  int            errors = 0;
  int            last_dut_g = N - 1;
  logic [N-1:0]  mon_ev;
  bit            mon_ey;

  function automatic logic [W-1:0] rand_pkt();
    logic [W-1:0] p;
    for (int b = 0; b < W; b += 32) p[b +: 32] = W'($urandom()) >> 0;
    return p;
  endfunction

  function automatic logic [DATA-1:0] resp_of(input logic [W-1:0] p);
    return p[DATA-1:0] ^ p[W-1 -: DATA];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arbitration rules: no issue when the cache stalls or four packets are in flight;
  // otherwise first eligible requester after the previous grantee, lock owner only.
  function automatic int model_grant(input logic [N-1:0] v, input logic cready);
    if (!cready || sb.size() >= ELS) return -1;
    for (int k = 1; k <= N; k++) begin
      int i = (m_last + k) % N;
      if (v[i] && (!m_locked || m_owner == i)) return i;
    end
    return -1;
  endfunction

  task automatic drive_cycle(input logic [N-1:0] v, input logic [N-1:0] lock,
                             input logic cready, output int dut_g);
    int           g;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    m_quiet               = 1'b0;
    bus.req_v_i           = v;
    bus.req_lock_i        = lock;
    bus.cache_pkt_ready_i = cready;
    for (int i = 0; i < N; i++) bus.req_pkt_i[i*W +: W] = pkt[i];
    bus.cache_v_i    = resp_en && (cq.size() > 0);
    bus.cache_data_i = (cq.size() > 0) ? resp_of(cq[0]) : {$urandom(), $urandom()};
    bus.req_yumi_i   = yumi_knob;
    #1;
    dut_g = -1;
    for (int i = 0; i < N; i++) if (bus.req_ready_o[i]) dut_g = i;
    if (dut_g >= 0) last_dut_g = dut_g;
    g         = model_grant(v, cready);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready_o", 128'(bus.req_ready_o), 128'(exp_ready));
    chk("cache_pkt_v_o", 128'(bus.cache_pkt_v_o), 128'(g >= 0));
    if (g >= 0) begin
      chk("cache_pkt_o", 128'(bus.cache_pkt_o), 128'(pkt[g]));
      sb.push_back('{g, resp_of(pkt[g])});
      m_last   = g;
      m_locked = lock[g];
      if (lock[g]) m_owner = g;
      pkt[g] = rand_pkt();
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      m_quiet = 1'b1;
      sb.delete();
      cq.delete();
      m_last = N - 1; m_locked = 1'b0; m_owner = 0;
      rst = 1'b1;
      bus.req_v_i = '1; bus.req_lock_i = '1; bus.req_yumi_i = '1;
      bus.cache_pkt_ready_i = 1'b1; bus.cache_v_i = 1'b1;
      bus.req_pkt_i = '1; bus.cache_data_i = '1;
      #1;
      chk("rst_req_ready_o", 128'(bus.req_ready_o), 128'(0));
      chk("rst_cache_pkt_v_o", 128'(bus.cache_pkt_v_o), 128'(0));
      chk("rst_req_v_o", 128'(bus.req_v_o), 128'(0));
      chk("rst_cache_yumi_o", 128'(bus.cache_yumi_o), 128'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    bus.req_v_i = '1; bus.req_lock_i = '0; bus.req_yumi_i = '1;
    bus.cache_pkt_ready_i = 1'b1; bus.cache_v_i = 1'b0;
    #1;
    chk("post_rst_req_ready_o", 128'(bus.req_ready_o), 128'(0));
    chk("post_rst_cache_pkt_v_o", 128'(bus.cache_pkt_v_o), 128'(0));
    chk("post_rst_req_v_o", 128'(bus.req_v_o), 128'(0));
    last_dut_g = N - 1;
  endtask

  task automatic drain();
    int g;
    int n = 0;
    resp_en = 1'b1; yumi_knob = '1;
    while (sb.size() > 0 && n < 40) begin
      drive_cycle('0, '0, 1'b1, g);
      n++;
    end
    drive_cycle('0, '0, 1'b1, g);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: outstanding %0d expected 0", sb.size());
    end
  endtask

  // Response monitor: pops the scoreboard whenever the DUT should hand a response over.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!m_quiet) begin
        mon_ev = '0;
        mon_ey = 1'b0;
        if (sb.size() > 0 && bus.cache_v_i) begin
          mon_ev[sb[0].g] = 1'b1;
          mon_ey          = bus.req_yumi_i[sb[0].g];
        end
        chk("req_v_o", 128'(bus.req_v_o), 128'(mon_ev));
        if (mon_ev != '0) chk("req_data_o", 128'(bus.req_data_o), 128'(sb[0].data));
        chk("cache_yumi_o", 128'(bus.cache_yumi_o), 128'(mon_ey));
        if (mon_ey) void'(sb.pop_front());
        #1;
        if (bus.cache_pkt_v_o && bus.cache_pkt_ready_i) cq.push_back(bus.cache_pkt_o);
        if (bus.cache_yumi_o && cq.size() > 0) void'(cq.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, cnt, sent, k, ref_g;
    int lock_exp [5] = '{1, 1, 1, 1, 0};
    logic [DATA-1:0] held;
    bus.req_v_i = '0; bus.req_lock_i = '0; bus.req_yumi_i = '0;
    bus.cache_pkt_ready_i = 1'b0; bus.cache_v_i = 1'b0;
    bus.req_pkt_i = '0; bus.cache_data_i = '0;
    for (int i = 0; i < N; i++) pkt[i] = rand_pkt();

    do_reset(3);

    // Round robin with both requesters streaming.
    resp_en = 1'b1; yumi_knob = '1;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(2'b11, 2'b00, 1'b1, g);
      chk("rr_grant", 128'(g), 128'(i % 2));
    end
    drain();

    // Lock burst from requester 1 while requester 0 keeps asking.
    drive_cycle(2'b01, 2'b00, 1'b1, g);
    chk("lock_pre_grant", 128'(g), 128'(0));
    sent = 0; k = 0; cnt = 0;
    while (sent < 4 && cnt < 20) begin
      if (sent == 2 && k == 2) begin
        drive_cycle(2'b01, 2'b00, 1'b1, g);
        chk("lock_idle_stall", 128'(g), 128'(-1));
        k = 3;
      end else begin
        drive_cycle(2'b11, {(sent < 3), 1'b0}, 1'b1, g);
        if (g >= 0) begin
          chk("lock_grant", 128'(g), 128'(lock_exp[sent]));
          if (g == 1) begin sent++; if (k < 2) k++; end
        end
      end
      cnt++;
    end
    drive_cycle(2'b01, 2'b00, 1'b1, g);
    chk("lock_release_grant", 128'(g), 128'(lock_exp[4]));
    drain();

    // Outstanding limit with the cache withholding responses.
    resp_en = 1'b0; cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(2'b01, 2'b00, 1'b1, g);
      if (g == 0) cnt++;
      if (i >= 4) chk("full_no_ready", 128'(g), 128'(-1));
    end
    chk("outstanding_accepts", 128'(cnt), 128'(4));
    resp_en = 1'b1;
    drive_cycle(2'b01, 2'b00, 1'b1, g);
    chk("full_deq_no_grant", 128'(g), 128'(-1));
    resp_en = 1'b0;
    drive_cycle(2'b01, 2'b00, 1'b1, g);
    chk("slot_reuse_grant", 128'(g), 128'(0));
    drain();

    // Response backpressure on a head owned by requester 1.
    resp_en = 1'b0; cnt = 0; g = -1;
    while (g != 1 && cnt < 10) begin
      drive_cycle(2'b10, 2'b00, 1'b1, g);
      cnt++;
    end
    resp_en = 1'b1; yumi_knob = 2'b01;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(2'b00, 2'b00, 1'b1, g);
      if (i == 0) held = bus.req_data_o;
      chk("bp_req_v_o", 128'(bus.req_v_o), 128'(2'b10));
      chk("bp_yumi_low", 128'(bus.cache_yumi_o), 128'(0));
      chk("bp_data_stable", 128'(bus.req_data_o), 128'(held));
    end
    yumi_knob = 2'b11;
    drive_cycle(2'b00, 2'b00, 1'b1, g);
    chk("bp_yumi_once", 128'(bus.cache_yumi_o), 128'(1));
    drive_cycle(2'b00, 2'b00, 1'b1, g);
    chk("bp_after_deq", 128'(bus.req_v_o), 128'(0));
    drain();

    // Cache not ready: no grant, pointer holds.
    ref_g = last_dut_g;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(2'b11, 2'b00, 1'b0, g);
      chk("cache_stall_no_grant", 128'(g), 128'(-1));
    end
    drive_cycle(2'b11, 2'b00, 1'b1, g);
    chk("cache_ready_next_rr", 128'(g), 128'((ref_g + 1) % N));
    drain();

    // Randomized traffic with a mid-run reset.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset(2);
      resp_en   = ($urandom_range(0, 9) < 7);
      yumi_knob = N'($urandom());
      drive_cycle(N'($urandom()), {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
                  ($urandom_range(0, 3) != 0), g);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
